// File: rtl/vrms_pkg.sv
// Shared types and width helpers for the multi-channel true-RMS calculator.
package vrms_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } eng_state_t;

  function automatic int chan_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Sum of 2^log2_win squares of w-bit samples can never exceed this width.
  function automatic int acc_width(input int w, input int log2_win);
    return 2 * w + log2_win;
  endfunction

endpackage

// File: rtl/vrms_calc_mc_isqrt.sv
// Sequential restoring square root: one root bit per cycle, MSB first, W cycles.
module isqrt_seq #(
  parameter int W = 12
) (
  input  logic           sys_clk,
  input  logic           rst,
  input  logic           abort,
  input  logic           start,
  input  logic [2*W-1:0] radicand,
  output logic           done,
  output logic [W-1:0]   root
);

  localparam int CNT_W = $clog2(W + 1);

  logic [2*W-1:0]   rad_q;
  logic [W+1:0]     rem_q;
  logic [W-1:0]     root_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  logic [W+3:0] rem_t;
  logic [W+3:0] trial;
  logic         take;
  logic [W+1:0] rem_nxt;

  // The remainder stays below 2*root+1, so W+2 bits always suffice.
  always_comb begin
    rem_t   = {rem_q, rad_q[2*W-1 -: 2]};
    trial   = {2'b00, root_q, 2'b01};
    take    = (rem_t >= trial);
    rem_nxt = take ? (W+2)'(rem_t - trial) : (W+2)'(rem_t);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (abort) begin
      run_q <= 1'b0;
    end else if (start) begin
      rad_q  <= radicand;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= CNT_W'(W);
      run_q  <= 1'b1;
    end else if (run_q) begin
      rad_q  <= rad_q << 2;
      rem_q  <= rem_nxt;
      root_q <= {root_q[W-2:0], take};
      cnt_q  <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) run_q <= 1'b0;
    end
  end

  // Flags the cycle whose clock edge produces the final root bit.
  assign done = run_q && (cnt_q == CNT_W'(1));
  assign root = root_q;

endmodule

// File: rtl/vrms_calc_mc.sv
// Multi-channel true-RMS: per-channel sum of squares over a 2^LOG2_WIN window,
// mean by shift, floor square root through one shared sequential engine.
module vrms_calc_mc
  import vrms_pkg::*;
#(
  parameter int W         = 12,
  parameter int N_CH      = 2,
  parameter int LOG2_WIN  = 10,
  parameter int SIGNED_IN = 1
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [chan_width(N_CH)-1:0] in_chan,
  input  logic [W-1:0]                in_data,
  input  logic                        clr,
  output logic                        rms_valid,
  output logic [chan_width(N_CH)-1:0] rms_chan,
  output logic [W-1:0]                rms_data,
  output logic [N_CH-1:0]             overrun,
  output logic                        busy
);

  localparam int            CW     = chan_width(N_CH);
  localparam int            AW     = acc_width(W, LOG2_WIN);
  localparam logic [CW:0]   N_CH_L = (CW+1)'(N_CH);

  logic [2*W-1:0]    sq_ext;
  logic [2*W-1:0]    sq_val;
  logic              accept;
  logic              sq_valid;
  logic [CW-1:0]     sq_chan;
  logic [2*W-1:0]    sq_q;

  logic [AW-1:0]       acc_q [N_CH];
  logic [LOG2_WIN-1:0] cnt_q [N_CH];
  logic [2*W-1:0]      ms_q  [N_CH];
  logic [N_CH-1:0]     pending_q;
  logic [N_CH-1:0]     pend_kept;
  logic [AW-1:0]       sum;
  logic                wrap;

  eng_state_t      state_q;
  eng_state_t      state_d;
  logic            start_sqrt;
  logic [N_CH-1:0] grant;
  logic [CW-1:0]   sel_chan;
  logic [CW-1:0]   eng_chan_q;
  logic            root_done;
  logic [W-1:0]    root;

  // The square of the sign-extended sample modulo 2^2W is the true square.
  assign sq_ext = (SIGNED_IN != 0) ? {{W{in_data[W-1]}}, in_data} : {{W{1'b0}}, in_data};
  assign sq_val = sq_ext * sq_ext;
  assign accept = in_valid && ({1'b0, in_chan} < N_CH_L) && !clr;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sq_valid <= 1'b0;
      sq_chan  <= '0;
      sq_q     <= '0;
    end else begin
      sq_valid <= accept;
      if (accept) begin
        sq_chan <= in_chan;
        sq_q    <= sq_val;
      end
    end
  end

  always_comb begin
    sum       = acc_q[sq_chan] + {{LOG2_WIN{1'b0}}, sq_q};
    wrap      = &cnt_q[sq_chan];
    pend_kept = pending_q & ~grant;
  end

  // A completion for a channel the engine is taking this cycle re-arms pending.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
        ms_q[i]  <= '0;
      end
      pending_q <= '0;
      overrun   <= '0;
    end else if (clr) begin
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
        ms_q[i]  <= '0;
      end
      pending_q <= '0;
      overrun   <= '0;
    end else begin
      pending_q <= pend_kept;
      if (sq_valid) begin
        cnt_q[sq_chan] <= cnt_q[sq_chan] + 1'b1;
        if (wrap) begin
          acc_q[sq_chan] <= '0;
          if (pend_kept[sq_chan]) begin
            overrun[sq_chan] <= 1'b1;
          end else begin
            ms_q[sq_chan]      <= sum[LOG2_WIN +: 2*W];
            pending_q[sq_chan] <= 1'b1;
          end
        end else begin
          acc_q[sq_chan] <= sum;
        end
      end
    end
  end

  always_comb begin
    sel_chan = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_chan = CW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    start_sqrt = 1'b0;
    grant      = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          start_sqrt      = 1'b1;
          grant[sel_chan] = 1'b1;
          state_d         = ITER;
        end
      end
      ITER:    if (root_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d    = IDLE;
      start_sqrt = 1'b0;
      grant      = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      eng_chan_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_sqrt) eng_chan_q <= sel_chan;
    end
  end

  isqrt_seq #(
    .W(W)
  ) u_isqrt (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .abort    (clr),
    .start    (start_sqrt),
    .radicand (ms_q[sel_chan]),
    .done     (root_done),
    .root     (root)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rms_valid <= 1'b0;
      rms_chan  <= '0;
      rms_data  <= '0;
    end else begin
      rms_valid <= (state_q == DONE) && !clr;
      if ((state_q == DONE) && !clr) begin
        rms_chan <= eng_chan_q;
        rms_data <= root;
      end
    end
  end

  assign busy = (state_q != IDLE) | (|pending_q);

endmodule

// File: tb/tb_vrms_calc_mc.sv
// Directed plus randomized bench: three instances share the input bus
// (signed L=4, unsigned L=4, signed L=1) and results come from a windowed RMS model.
module tb_vrms_calc_mc;

  localparam int W = 12;

  logic         sys_clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_chan;
  logic [W-1:0] in_data;
  logic         clr;

  logic m_rms_valid, u_rms_valid, o_rms_valid;
  logic m_rms_chan,  u_rms_chan,  o_rms_chan;
  logic [W-1:0] m_rms_data, u_rms_data, o_rms_data;
  logic [1:0]   m_overrun,  u_overrun,  o_overrun;
  logic m_busy, u_busy, o_busy;

  int compared   = 0;
  int mismatched = 0;
  bit model_en   = 1'b0;
  bit mon_en     = 1'b0;
  longint sum_m[2];
  int     cnt_m[2];
  int     exp_q0[$];
  int     exp_q1[$];
  int     mon_e;
  int     k;
  int     c;

  always #5 sys_clk = ~sys_clk;

  vrms_calc_mc #(.W(W), .N_CH(2), .LOG2_WIN(4), .SIGNED_IN(1)) u_main (
    .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_chan(in_chan),
    .in_data(in_data), .clr(clr), .rms_valid(m_rms_valid), .rms_chan(m_rms_chan),
    .rms_data(m_rms_data), .overrun(m_overrun), .busy(m_busy));

  vrms_calc_mc #(.W(W), .N_CH(2), .LOG2_WIN(4), .SIGNED_IN(0)) u_uns (
    .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_chan(in_chan),
    .in_data(in_data), .clr(clr), .rms_valid(u_rms_valid), .rms_chan(u_rms_chan),
    .rms_data(u_rms_data), .overrun(u_overrun), .busy(u_busy));

  vrms_calc_mc #(.W(W), .N_CH(2), .LOG2_WIN(1), .SIGNED_IN(1)) u_ovr (
    .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_chan(in_chan),
    .in_data(in_data), .clr(clr), .rms_valid(o_rms_valid), .rms_chan(o_rms_chan),
    .rms_data(o_rms_data), .overrun(o_overrun), .busy(o_busy));

  function automatic int isqrtFloor(input longint m);
    int r = 0;
    while (longint'(r + 1) * longint'(r + 1) <= m) r++;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: RMS of each completed 16-sample window of the signed instance.
  task automatic modelPush(input int ch, input int d);
    logic signed [W-1:0] s12;
    longint s;
    s12 = d[W-1:0];
    s = longint'(s12);
    sum_m[ch] += s * s;
    cnt_m[ch]++;
    if (cnt_m[ch] == 16) begin
      if (ch == 0) exp_q0.push_back(isqrtFloor(sum_m[ch] / 16));
      else         exp_q1.push_back(isqrtFloor(sum_m[ch] / 16));
      sum_m[ch] = 0;
      cnt_m[ch] = 0;
    end
  endtask

  task automatic applyStimulus(input logic v, input int ch, input int d, input logic cl);
    in_valid = v;
    in_chan  = ch[0];
    in_data  = d[W-1:0];
    clr      = cl;
    if (model_en && v && !cl) modelPush(ch, d);
    @(negedge sys_clk);
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 0, 0, 1'b0);
  endtask

  function automatic logic strobeOf(input int inst);
    return (inst == 0) ? m_rms_valid : (inst == 1) ? u_rms_valid : o_rms_valid;
  endfunction

  function automatic logic chanOf(input int inst);
    return (inst == 0) ? m_rms_chan : (inst == 1) ? u_rms_chan : o_rms_chan;
  endfunction

  function automatic logic [W-1:0] dataOf(input int inst);
    return (inst == 0) ? m_rms_data : (inst == 1) ? u_rms_data : o_rms_data;
  endfunction

  task automatic waitStrobe(input int inst, input string tag, input int exp_chan,
                            input int exp_data, input int budget, output int cyc);
    bit found = 1'b0;
    cyc = 0;
    for (int i = 1; i <= budget && !found; i++) begin
      if (strobeOf(inst)) begin
        found = 1'b1;
        cyc   = i;
      end else begin
        @(negedge sys_clk);
      end
    end
    checkOutput({tag, "_seen"}, 64'(found), 64'd1);
    if (found) begin
      checkOutput({tag, "_chan"}, 64'(chanOf(inst)), 64'(exp_chan));
      checkOutput({tag, "_data"}, 64'(dataOf(inst)), 64'(exp_data));
      @(negedge sys_clk);
    end
  endtask

  task automatic countStrobes(input int inst, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      if (strobeOf(inst)) cnt++;
      @(negedge sys_clk);
    end
  endtask

  always @(negedge sys_clk) begin
    if (mon_en && m_rms_valid) begin
      if (m_rms_chan == 1'b0) begin
        if (exp_q0.size() == 0) checkOutput("rand_extra_ch0", 64'd1, 64'd0);
        else begin
          mon_e = exp_q0.pop_front();
          checkOutput("rand_ch0", 64'(m_rms_data), 64'(mon_e));
        end
      end else begin
        if (exp_q1.size() == 0) checkOutput("rand_extra_ch1", 64'd1, 64'd0);
        else begin
          mon_e = exp_q1.pop_front();
          checkOutput("rand_ch1", 64'(m_rms_data), 64'(mon_e));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_chan = 1'b0; in_data = '0; clr = 1'b0;
    sum_m[0] = 0; sum_m[1] = 0; cnt_m[0] = 0; cnt_m[1] = 0;
    repeat (2) @(negedge sys_clk);
    checkOutput("rst_valid", 64'(m_rms_valid), 64'd0);
    checkOutput("rst_chan", 64'(m_rms_chan), 64'd0);
    checkOutput("rst_data", 64'(m_rms_data), 64'd0);
    checkOutput("rst_overrun", 64'(m_overrun), 64'd0);
    checkOutput("rst_busy", 64'(m_busy), 64'd0);
    rst = 1'b0;
    @(negedge sys_clk);

    $display("[TB] constant +1000 on ch0");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 0, 1000, 1'b0);
    waitStrobe(0, "const", 0, 1000, 40, k);
    checkOutput("const_latency", 64'(k), 64'(W + 4));
    checkOutput("const_overrun", 64'(m_overrun), 64'd0);

    $display("[TB] alternating full scale on ch1");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1, (i % 2 == 0) ? 2047 : -2047, 1'b0);
    waitStrobe(0, "alt", 1, 2047, 40, k);

    $display("[TB] negative full scale on ch0");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 0, -2048, 1'b0);
    waitStrobe(0, "negfs", 0, 2048, 40, k);

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 0, 0, 1'b0);
    waitStrobe(0, "zero", 0, 0, 40, k);

    $display("[TB] floor rounding 3/4 on ch1");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1, (i % 2 == 0) ? 3 : 4, 1'b0);
    waitStrobe(0, "floor", 1, 3, 40, k);

    $display("[TB] interleaved windows");
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, i % 2, (i % 2 == 0) ? 500 : -300, 1'b0);
    waitStrobe(0, "inter0", 0, 500, 40, k);
    waitStrobe(0, "inter1", 1, 300, 40, k);
    checkOutput("inter_gap", 64'(k), 64'(W + 2));

    $display("[TB] unsigned full scale");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 0, 4095, 1'b0);
    waitStrobe(1, "uns", 0, 4095, 40, k);
    checkOutput("signed_minus1", 64'(m_rms_data), 64'd1);

    $display("[TB] overrun and clear");
    applyStimulus(1'b0, 0, 0, 1'b1);
    checkOutput("clr_ovr_overrun", 64'(o_overrun), 64'd0);
    checkOutput("clr_ovr_busy", 64'(o_busy), 64'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 0, 10, 1'b0);
    checkOutput("ovr_set", 64'(o_overrun), 64'd1);
    idle(30);
    checkOutput("ovr_sticky", 64'(o_overrun), 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 10, 1'b0);
    checkOutput("ovr_busy_before_clr", 64'(o_busy), 64'd1);
    applyStimulus(1'b0, 0, 0, 1'b1);
    checkOutput("clr_overrun", 64'(o_overrun), 64'd0);
    checkOutput("clr_busy", 64'(o_busy), 64'd0);
    checkOutput("clr_main_busy", 64'(m_busy), 64'd0);
    countStrobes(2, 20, c);
    checkOutput("clr_no_strobe", 64'(c), 64'd0);

    $display("[TB] reset mid-window");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 0, 700, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rstw_data", 64'(m_rms_data), 64'd0);
    checkOutput("rstw_busy", 64'(m_busy), 64'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    countStrobes(0, 30, c);
    checkOutput("rstw_no_strobe", 64'(c), 64'd0);

    $display("[TB] reset during square root");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1, 900, 1'b0);
    idle(5);
    checkOutput("rsti_busy_before", 64'(m_busy), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rsti_busy", 64'(m_busy), 64'd0);
    checkOutput("rsti_valid", 64'(m_rms_valid), 64'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    countStrobes(0, 30, c);
    checkOutput("rsti_no_strobe", 64'(c), 64'd0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 0, 100, 1'b0);
    waitStrobe(0, "fresh", 0, 100, 40, k);

    $display("[TB] randomized windows against model");
    applyStimulus(1'b0, 0, 0, 1'b1);
    model_en = 1'b1;
    mon_en   = 1'b1;
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom % 4) != 0, i % 2, int'($urandom_range(4095, 0)), 1'b0);
    model_en = 1'b0;
    idle(60);
    mon_en = 1'b0;
    checkOutput("rand_pending_ch0", 64'(exp_q0.size()), 64'd0);
    checkOutput("rand_pending_ch1", 64'(exp_q1.size()), 64'd0);
    checkOutput("rand_overrun", 64'(m_overrun), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
